// File: rtl/regfile_pkg.sv
// Shared types for the regfile initiator: default widths, FSM state and command record.
package regfile_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int LW_DEF = 4;

  typedef logic [AW_DEF-1:0] rf_addr_t;
  typedef logic [DW_DEF-1:0] rf_data_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ} rfm_state_e;

  typedef struct packed {
    logic              write;
    rf_addr_t          addr;
    logic [LW_DEF-1:0] len;
  } rf_cmd_t;
endpackage

// File: rtl/regfile_master_if.sv
// Command/W/R streams plus the regfile access port; master = initiator, slave = environment.
interface regfile_master_if
  import regfile_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic          r_valid;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic          busy;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_din;
  logic          rf_ren;
  logic          rf_wen;
  logic [DW-1:0] rf_dout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, w_valid, w_data, r_ready, rf_dout,
    output cmd_ready, w_ready, r_valid, r_data, r_last, busy, rf_addr, rf_din, rf_ren, rf_wen
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, w_valid, w_data, r_ready, rf_dout,
    input  cmd_ready, w_ready, r_valid, r_data, r_last, busy, rf_addr, rf_din, rf_ren, rf_wen
  );
endinterface

// File: rtl/rf_resp_fifo.sv
// Read-response FIFO: data plus last flag per entry, occupancy count exported for credit checks.
module rf_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rp];
  assign empty = (count == '0);
endmodule

// File: rtl/regfile_master.sv
// Burst-to-single-beat regfile initiator with credit-limited reads into a response FIFO.
// Optional REGFILE_MASTER_STATS_EN adds saturating stat_rd/stat_wr cycle counters.
module regfile_master
  import regfile_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int LW         = LW_DEF,
  parameter int RD_LATENCY = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef REGFILE_MASTER_STATS_EN
  output logic [15:0] stat_rd,
  output logic [15:0] stat_wr,
`endif
  regfile_master_if.master bus
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int OW = $clog2(RESP_DEPTH + RD_LATENCY + 2) + 1;

  rfm_state_e      state;
  logic [AW-1:0]   cur;
  logic [LW-1:0]   left;
  logic            cmd_ready_q, w_ready_q;
  logic [AW-1:0]   rf_addr_q;
  logic [DW-1:0]   rf_din_q;
  logic            rf_ren_q, rf_wen_q, rf_last_q;
  logic [RD_LATENCY-1:0] vld_sh, last_sh;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic [DW:0]     fifo_dout;
  logic [OW-1:0]   inflight, occ;
  logic            issue, w_hs, pop;

  // Reads already issued but not yet in the FIFO still consume a slot.
  always_comb begin
    inflight = OW'(rf_ren_q);
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + OW'(vld_sh[i]);
    occ   = inflight + OW'(fifo_count);
    issue = (state == READ) && (occ < OW'(RESP_DEPTH));
    w_hs  = (state == WRITE) && w_ready_q && bus.w_valid;
    pop   = !fifo_empty && bus.r_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= '0;
      left        <= '0;
      cmd_ready_q <= 1'b0;
      w_ready_q   <= 1'b0;
      rf_addr_q   <= '0;
      rf_din_q    <= '0;
      rf_ren_q    <= 1'b0;
      rf_wen_q    <= 1'b0;
      rf_last_q   <= 1'b0;
    end else begin
      rf_ren_q <= 1'b0;
      rf_wen_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_ready_q && bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            cur         <= bus.cmd_addr;
            left        <= bus.cmd_len;
            if (bus.cmd_write) begin
              state     <= WRITE;
              w_ready_q <= 1'b1;
            end else begin
              state <= READ;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        WRITE: begin
          if (w_hs) begin
            rf_wen_q  <= 1'b1;
            rf_addr_q <= cur;
            rf_din_q  <= bus.w_data;
            cur       <= cur + 1'b1;
            left      <= left - 1'b1;
            if (left == '0) begin
              state       <= IDLE;
              w_ready_q   <= 1'b0;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            rf_ren_q  <= 1'b1;
            rf_addr_q <= cur;
            rf_last_q <= (left == '0);
            cur       <= cur + 1'b1;
            left      <= left - 1'b1;
            if (left == '0) begin
              state       <= IDLE;
              cmd_ready_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return alignment: stage RD_LATENCY-1 lines up with valid rf_dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sh  <= '0;
      last_sh <= '0;
    end else begin
      vld_sh[0]  <= rf_ren_q;
      last_sh[0] <= rf_ren_q & rf_last_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sh[i]  <= vld_sh[i-1];
        last_sh[i] <= last_sh[i-1];
      end
    end
  end

  rf_resp_fifo #(.DEPTH(RESP_DEPTH), .W(DW + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_sh[RD_LATENCY-1]),
    .din   ({last_sh[RD_LATENCY-1], bus.rf_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef REGFILE_MASTER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd <= '0;
      stat_wr <= '0;
    end else begin
      if (rf_ren_q && stat_rd != 16'hFFFF) stat_rd <= stat_rd + 1'b1;
      if (rf_wen_q && stat_wr != 16'hFFFF) stat_wr <= stat_wr + 1'b1;
    end
  end
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.w_ready   = w_ready_q;
  assign bus.rf_addr   = rf_addr_q;
  assign bus.rf_din    = rf_din_q;
  assign bus.rf_ren    = rf_ren_q;
  assign bus.rf_wen    = rf_wen_q;
  assign bus.r_valid   = !fifo_empty;
  assign bus.r_data    = fifo_empty ? '0 : fifo_dout[DW-1:0];
  assign bus.r_last    = !fifo_empty && fifo_dout[DW];
  assign bus.busy      = (state != IDLE) || (inflight != '0) || !fifo_empty;
endmodule

// File: tb/tb_regfile_master.sv
// Directed bench for regfile_master: burst table plus stall, wrap, gap and mid-burst reset sequences.
module tb_regfile_master;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_master_if #(.AW(8), .DW(8), .LW(4)) bus ();

`ifdef REGFILE_MASTER_STATS_EN
  logic [15:0] stat_rd, stat_wr;
`endif

  regfile_master #(.AW(8), .DW(8), .LW(4), .RD_LATENCY(1), .RESP_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef REGFILE_MASTER_STATS_EN
    .stat_rd (stat_rd),
    .stat_wr (stat_wr),
`endif
    .bus     (bus)
  );

  // Regfile model: unwritten locations read back as addr ^ 0x5A.
  logic [7:0] mem [256];
  bit         written [256];
  always @(posedge clk) begin
    if (bus.rf_wen) begin
      mem[bus.rf_addr]     <= bus.rf_din;
      written[bus.rf_addr] <= 1'b1;
    end
    if (bus.rf_ren) bus.rf_dout <= written[bus.rf_addr] ? mem[bus.rf_addr] : (bus.rf_addr ^ 8'h5A);
  end

  logic [7:0] wq_a[$], wq_d[$], raq[$], rq_d[$];
  logic       rq_l[$];
  int         excl_err = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rf_wen) begin
        wq_a.push_back(bus.rf_addr);
        wq_d.push_back(bus.rf_din);
      end
      if (bus.rf_ren) raq.push_back(bus.rf_addr);
      if (bus.rf_ren && bus.rf_wen) excl_err++;
      if (bus.r_valid && bus.r_ready) begin
        rq_d.push_back(bus.r_data);
        rq_l.push_back(bus.r_last);
      end
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: timed out waiting, got none, expected handshake", name);
  endtask

  task automatic clear_q();
    wq_a.delete(); wq_d.delete(); raq.delete(); rq_d.delete(); rq_l.delete();
  endtask

  task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [3:0] l);
    int t;
    t = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = l;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      t++;
      if (t > 100) begin tmo("cmd_ready"); break; end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      @(posedge clk); #1;
      if (gap > 0) begin
        bus.w_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      bus.w_valid = 1'b1;
      bus.w_data  = d[8*i +: 8];
      forever begin
        @(negedge clk);
        if (bus.w_ready) break;
        t++;
        if (t > 100) begin tmo("w_ready"); break; end
      end
    end
    @(posedge clk); #1;
    bus.w_valid = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [31:0] data;
    int          gap;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n, t, lat;
    logic [7:0] ea;
    n = int'(v.len) + 1;
    @(posedge clk); #1;
    clear_q();
    send_cmd(v.wr, v.addr, v.len);
    if (v.wr) begin
      send_w(v.data, n, v.gap);
      repeat (3) @(negedge clk);
      chk("wr_beats", wq_a.size(), n);
      for (int i = 0; i < n && i < wq_a.size(); i++) begin
        ea = v.addr + 8'(i);
        chk("wr_addr", wq_a[i], ea);
        chk("wr_din", wq_d[i], v.data[8*i +: 8]);
      end
    end else begin
      t = 0;
      forever begin
        @(negedge clk);
        if (bus.rf_ren) break;
        t++;
        if (t > 50) begin tmo("rf_ren"); break; end
      end
      lat = 0;
      while (!bus.r_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("rd_latency", lat, 2);
      t = 0;
      while (rq_d.size() < n && t < 100) begin
        @(negedge clk);
        t++;
      end
      repeat (2) @(negedge clk);
      chk("rd_beats", rq_d.size(), n);
      for (int i = 0; i < n && i < rq_d.size(); i++) begin
        ea = v.addr + 8'(i);
        chk("rd_data", rq_d[i], v.data[8*i +: 8]);
        chk("rd_last", rq_l[i], (i == n - 1));
        chk("rd_addr", raq[i], ea);
      end
    end
    chk("busy_done", bus.busy, 1'b0);
  endtask

  vec_t tbl [6];

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int t;
    logic [7:0] ed;
    tbl[0] = '{wr: 1'b1, addr: 8'h00, len: 4'd3, data: 32'h06040200, gap: 0};
    tbl[1] = '{wr: 1'b0, addr: 8'h00, len: 4'd3, data: 32'h06040200, gap: 0};
    tbl[2] = '{wr: 1'b1, addr: 8'hFE, len: 4'd2, data: 32'h00C3B2A1, gap: 1};
    tbl[3] = '{wr: 1'b0, addr: 8'hFE, len: 4'd2, data: 32'h00C3B2A1, gap: 0};
    tbl[4] = '{wr: 1'b1, addr: 8'h10, len: 4'd0, data: 32'h0000005A, gap: 2};
    tbl[5] = '{wr: 1'b0, addr: 8'h10, len: 4'd0, data: 32'h0000005A, gap: 0};

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.w_valid = 1'b0; bus.w_data = '0; bus.r_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_rf_ren", bus.rf_ren, 1'b0);
    chk("rst_rf_wen", bus.rf_wen, 1'b0);
    chk("rst_r_valid", bus.r_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i]);
`ifdef REGFILE_MASTER_STATS_EN
      if (i == 1) begin
        chk("stat_wr", stat_wr, 16'd4);
        chk("stat_rd", stat_rd, 16'd4);
      end
`endif
    end

    // Credit stall: consumer blocked, only RESP_DEPTH reads may be issued.
    @(posedge clk); #1;
    clear_q();
    bus.r_ready = 1'b0;
    send_cmd(1'b0, 8'h20, 4'd15);
    repeat (20) @(negedge clk);
    chk("stall_issues", raq.size(), 4);
    chk("stall_rf_ren", bus.rf_ren, 1'b0);
    chk("stall_r_valid", bus.r_valid, 1'b1);
    chk("stall_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    bus.r_ready = 1'b1;
    t = 0;
    while (rq_d.size() < 16 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("stall_beats", rq_d.size(), 16);
    chk("stall_issued", raq.size(), 16);
    for (int i = 0; i < 16 && i < rq_d.size(); i++) begin
      ed = (8'h20 + 8'(i)) ^ 8'h5A;
      chk("stall_data", rq_d[i], ed);
      chk("stall_last", rq_l[i], (i == 15));
    end
    chk("stall_busy_done", bus.busy, 1'b0);

    // Asynchronous reset in the middle of a blocked read burst.
    @(posedge clk); #1;
    clear_q();
    bus.r_ready = 1'b0;
    send_cmd(1'b0, 8'h30, 4'd15);
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_issued", (raq.size() > 0), 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rf_ren", bus.rf_ren, 1'b0);
    chk("mid_rst_rf_wen", bus.rf_wen, 1'b0);
    chk("mid_rst_r_valid", bus.r_valid, 1'b0);
    chk("mid_rst_r_data", bus.r_data, 8'h00);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.r_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_r_valid", bus.r_valid, 1'b0);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

    v = '{wr: 1'b1, addr: 8'h30, len: 4'd1, data: 32'h00008877, gap: 1};
    run_vec(v);
    v.wr = 1'b0;
    v.gap = 0;
    run_vec(v);

    chk("ren_wen_exclusive", excl_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
